// File: rtl/vec_reg_wb_responder.sv
// Write-back responder: arbitrates NUM_OF_WB write requests into the vector register file, 1-cycle response, debug read port.
// Grant is combinational (none under wr_stall/reset); round-robin when VREG_WB_FAIR_ARB_EN is defined, else fixed priority.
package vec_reg_pkg;
    localparam int ADDR_FIELD_WIDTH = 16;
    localparam int VREG_PTR_W       = 5;
    localparam int VREG_DATA_W      = 64;

    typedef enum logic [1:0] {
        READ_REQ  = 2'd0,
        WRITE_REQ = 2'd1
    } access_type_e;

    typedef enum logic {
        NON_STRIDE = 1'b0,
        STRIDE     = 1'b1
    } stride_type_e;

    typedef struct packed {
        logic                        vld;
        access_type_e                access_type;
        logic [7:0]                  access_length;
        stride_type_e                stride_type;
        logic [VREG_PTR_W-1:0]       vec_reg_ptr;
        logic [ADDR_FIELD_WIDTH-1:0] addr;
        logic [VREG_DATA_W-1:0]      data;
    } cntrl_req_t;
endpackage

module vec_reg_wb_responder
    import vec_reg_pkg::*;
#(
    parameter int NUM_OF_WB         = 3,
    parameter int NUM_OF_VECTOR_REG = 32,
    parameter int VEC_DEPTH         = 64,
    parameter int VECTOR_REG_WIDTH  = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  cntrl_req_t                           wb_reg_req       [NUM_OF_WB],
    output logic                                 wb_reg_req_grant [NUM_OF_WB],
    output logic                                 wb_reg_rsp_vld   [NUM_OF_WB],
    output logic [VECTOR_REG_WIDTH-1:0]          wb_reg_rsp_data  [NUM_OF_WB],
    output logic                                 wb_reg_rsp_err   [NUM_OF_WB],
    input  logic                                 wr_stall,
    input  logic                                 rd_vld,
    input  logic [$clog2(NUM_OF_VECTOR_REG)-1:0] rd_reg,
    input  logic [$clog2(VEC_DEPTH)-1:0]         rd_addr,
    output logic [VECTOR_REG_WIDTH-1:0]          rd_data,
    output logic [7:0]                           err_cnt
);
    localparam int REG_W  = $clog2(NUM_OF_VECTOR_REG);
    localparam int ELEM_W = $clog2(VEC_DEPTH);
    localparam int PTR_W  = (NUM_OF_WB > 1) ? $clog2(NUM_OF_WB) : 1;
    localparam int MEM_W  = REG_W + ELEM_W;

    logic [VECTOR_REG_WIDTH-1:0] r_mem [NUM_OF_VECTOR_REG*VEC_DEPTH];

    logic                        r_rsp_vld  [NUM_OF_WB];
    logic [VECTOR_REG_WIDTH-1:0] r_rsp_data [NUM_OF_WB];
    logic                        r_rsp_err  [NUM_OF_WB];
    logic [VECTOR_REG_WIDTH-1:0] r_rd_data;
    logic [7:0]                  r_err_cnt;

    logic [PTR_W-1:0] w_start;
    logic             w_found;
    cntrl_req_t       w_sel;
    logic             w_legal;
    logic             w_wr_en;
    logic [MEM_W-1:0] w_wr_idx;
    logic [MEM_W-1:0] w_rd_idx;
    logic             w_unused_addr;

    // Two passes give a wrap-around search starting at w_start without modulo indexing.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_OF_WB; i++) begin
            wb_reg_req_grant[i] = 1'b0;
        end
        if (!reset && !wr_stall) begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                if (!w_found && wb_reg_req[i].vld && (PTR_W'(i) >= w_start)) begin
                    w_found             = 1'b1;
                    w_sel               = wb_reg_req[i];
                    wb_reg_req_grant[i] = 1'b1;
                end
            end
            for (int i = 0; i < NUM_OF_WB; i++) begin
                if (!w_found && wb_reg_req[i].vld && (PTR_W'(i) < w_start)) begin
                    w_found             = 1'b1;
                    w_sel               = wb_reg_req[i];
                    wb_reg_req_grant[i] = 1'b1;
                end
            end
        end
    end

    assign w_legal  = (w_sel.access_type == WRITE_REQ) && (w_sel.access_length == 8'd1) &&
                      (w_sel.stride_type == NON_STRIDE);
    assign w_wr_en  = w_found && w_legal;
    assign w_wr_idx = {w_sel.vec_reg_ptr[REG_W-1:0], w_sel.addr[ELEM_W-1:0]};
    assign w_rd_idx = {rd_reg, rd_addr};
    assign w_unused_addr = ^w_sel.addr[ADDR_FIELD_WIDTH-1:ELEM_W];

`ifdef VREG_WB_FAIR_ARB_EN
    logic [PTR_W-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                if (wb_reg_req_grant[i]) begin
                    r_rr_ptr <= PTR_W'((i + 1) % NUM_OF_WB);
                end
            end
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_sel.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                r_rsp_vld[i]  <= 1'b0;
                r_rsp_data[i] <= '0;
                r_rsp_err[i]  <= 1'b0;
            end
            r_rd_data <= '0;
            r_err_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                r_rsp_vld[i] <= wb_reg_req_grant[i];
                if (wb_reg_req_grant[i]) begin
                    r_rsp_data[i] <= w_legal ? w_sel.data : '0;
                    r_rsp_err[i]  <= !w_legal;
                end
            end
            if (w_found && !w_legal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            // Write-first: a same-cycle commit to the read location is forwarded.
            if (rd_vld) begin
                r_rd_data <= (w_wr_en && (w_wr_idx == w_rd_idx)) ? w_sel.data : r_mem[w_rd_idx];
            end
        end
    end

    assign wb_reg_rsp_vld  = r_rsp_vld;
    assign wb_reg_rsp_data = r_rsp_data;
    assign wb_reg_rsp_err  = r_rsp_err;
    assign rd_data         = r_rd_data;
    assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_vec_reg_wb_responder.sv
// Directed bench for vec_reg_wb_responder: write/readback, arbitration, stall, illegal requests, bypass, reset.
module tb_vec_reg_wb_responder;
    import vec_reg_pkg::*;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    cntrl_req_t  req      [N];
    logic        gnt      [N];
    logic        rsp_vld  [N];
    logic [63:0] rsp_data [N];
    logic        rsp_err  [N];
    logic        wr_stall;
    logic        rd_vld;
    logic [4:0]  rd_reg;
    logic [5:0]  rd_addr;
    logic [63:0] rd_data;
    logic [7:0]  err_cnt;

    logic [2:0]  gv;
    logic [2:0]  rv;
    logic [2:0]  exp_g;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign gv = {gnt[2], gnt[1], gnt[0]};
    assign rv = {rsp_vld[2], rsp_vld[1], rsp_vld[0]};

    vec_reg_wb_responder dut (
        .clk              (clk),
        .reset            (reset),
        .wb_reg_req       (req),
        .wb_reg_req_grant (gnt),
        .wb_reg_rsp_vld   (rsp_vld),
        .wb_reg_rsp_data  (rsp_data),
        .wb_reg_rsp_err   (rsp_err),
        .wr_stall         (wr_stall),
        .rd_vld           (rd_vld),
        .rd_reg           (rd_reg),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .err_cnt          (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cntrl_req_t mk_wr(input logic [4:0] r, input logic [15:0] a, input logic [63:0] d);
        cntrl_req_t q;
        q               = '0;
        q.vld           = 1'b1;
        q.access_type   = WRITE_REQ;
        q.access_length = 8'd1;
        q.stride_type   = NON_STRIDE;
        q.vec_reg_ptr   = r;
        q.addr          = a;
        q.data          = d;
        return q;
    endfunction

    task automatic clr_reqs();
        for (int i = 0; i < N; i++) req[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_stall = 1'b0; rd_vld = 1'b0; rd_reg = '0; rd_addr = '0;
        clr_reqs();
        req[0] = mk_wr(5'd31, 16'd63, 64'hDEAD);
        repeat (2) step();
        chk("rst_grant", 64'(gv), 64'd0);
        chk("rst_rsp_vld", 64'(rv), 64'd0);
        chk("rst_rsp_data0", rsp_data[0], 64'd0);
        chk("rst_rsp_err", 64'({rsp_err[2], rsp_err[1], rsp_err[0]}), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);

        // single write then readback
        @(negedge clk); reset = 1'b0; clr_reqs();
        @(negedge clk); req[0] = mk_wr(5'd5, 16'd3, 64'hA5A5);
        #1 chk("w1_grant", 64'(gv), 64'b001);
        step();
        chk("w1_rsp_vld", 64'(rv), 64'b001);
        chk("w1_rsp_data", rsp_data[0], 64'hA5A5);
        chk("w1_rsp_err", 64'(rsp_err[0]), 64'd0);
        @(negedge clk); clr_reqs(); rd_vld = 1'b1; rd_reg = 5'd5; rd_addr = 6'd3;
        step();
        chk("w1_readback", rd_data, 64'hA5A5);
        chk("w1_rsp_drop", 64'(rv), 64'd0);

        // stall holds off port1
        @(negedge clk); rd_vld = 1'b0; wr_stall = 1'b1; req[1] = mk_wr(5'd1, 16'd1, 64'h11);
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall_grant", 64'(gv), 64'd0);
            step();
            chk("stall_rsp", 64'(rv), 64'd0);
            @(negedge clk);
        end
        wr_stall = 1'b0;
        #1 chk("unstall_grant", 64'(gv), 64'b010);
        step();
        chk("unstall_rsp", 64'(rv), 64'b010);
        chk("unstall_data", rsp_data[1], 64'h11);

        // arbitration with all three ports requesting, pointer freshly reset
        @(negedge clk); clr_reqs(); reset = 1'b1;
        step();
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < N; i++) req[i] = mk_wr(5'(10 + i), 16'd0, 64'(256 + i));
        for (int c = 0; c < 6; c++) begin
`ifdef VREG_WB_FAIR_ARB_EN
            exp_g = 3'b001 << (c % 3);
`else
            exp_g = 3'b001;
`endif
            #1 chk("arb_grant", 64'(gv), 64'(exp_g));
            step();
            chk("arb_rsp", 64'(rv), 64'(exp_g));
            @(negedge clk);
        end
        clr_reqs();

        // illegal request leaves storage untouched
        req[2] = mk_wr(5'd20, 16'd4, 64'hBEEF);
        step();
        @(negedge clk); clr_reqs(); rd_vld = 1'b1; rd_reg = 5'd20; rd_addr = 6'd4;
        step();
        chk("ill_pre_read", rd_data, 64'hBEEF);
        @(negedge clk); rd_vld = 1'b0;
        req[2] = mk_wr(5'd20, 16'd4, 64'hDEAD);
        req[2].access_type = READ_REQ;
        #1 chk("ill_grant", 64'(gv), 64'b100);
        step();
        chk("ill_rsp_vld", 64'(rv), 64'b100);
        chk("ill_rsp_err", 64'(rsp_err[2]), 64'd1);
        chk("ill_rsp_data", rsp_data[2], 64'd0);
        chk("ill_err_cnt", 64'(err_cnt), 64'd1);
        @(negedge clk); clr_reqs(); rd_vld = 1'b1;
        step();
        chk("ill_post_read", rd_data, 64'hBEEF);
        rd_vld = 1'b0;
        for (int k = 0; k < 259; k++) begin
            @(negedge clk);
            req[2] = mk_wr(5'd20, 16'd4, 64'(k));
            case (k % 3)
                0:       req[2].access_type   = READ_REQ;
                1:       req[2].access_length = 8'd2;
                default: req[2].stride_type   = STRIDE;
            endcase
            step();
            if (k == 253) chk("err_cnt_255", 64'(err_cnt), 64'd255);
        end
        chk("err_cnt_sat", 64'(err_cnt), 64'd255);
        @(negedge clk); clr_reqs(); rd_vld = 1'b1;
        step();
        chk("ill_many_read", rd_data, 64'hBEEF);

        // write-first bypass, upper address bits ignored
        @(negedge clk); rd_reg = 5'd7; rd_addr = 6'd0; req[0] = mk_wr(5'd7, 16'h0040, 64'h1234);
        step();
        chk("bypass_rd", rd_data, 64'h1234);
        chk("bypass_rsp", rsp_data[0], 64'h1234);
        @(negedge clk); rd_vld = 1'b0; req[0] = mk_wr(5'd7, 16'd0, 64'h7777);
        step();
        chk("rd_hold", rd_data, 64'h1234);
        @(negedge clk); clr_reqs(); rd_vld = 1'b1;
        step();
        chk("rd_after_write", rd_data, 64'h7777);

        // reset mid-stream suppresses the pending write
        @(negedge clk); rd_vld = 1'b0; reset = 1'b1; req[0] = mk_wr(5'd5, 16'd3, 64'h5555);
        #1 chk("mid_rst_grant", 64'(gv), 64'd0);
        step();
        chk("mid_rst_rsp_vld", 64'(rv), 64'd0);
        chk("mid_rst_rsp_data0", rsp_data[0], 64'd0);
        chk("mid_rst_rsp_err2", 64'(rsp_err[2]), 64'd0);
        chk("mid_rst_rd_data", rd_data, 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk); reset = 1'b0; clr_reqs(); rd_vld = 1'b1; rd_reg = 5'd5; rd_addr = 6'd3;
        step();
        chk("mid_rst_elem", rd_data, 64'hA5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
